// File: rtl/cpu_io_pkg.sv
// Shared types, seven-segment constants and the digit decoder for the CPU I/O responder.
package cpu_io_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [31:0] DISP_MAX = 32'd999;

  typedef enum logic {RD_IDLE, RD_WAIT} rd_state_t;
  typedef enum logic {WR_IDLE, WR_CONV} wr_state_t;

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/cpu_io_responder_debounce.sv
// Pushbutton front end: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each debounced press (active-low button).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // A flip away from released (1) is a press; the opposite flip is silent.
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d   = sync2_q;
        press_d = deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/cpu_io_responder.sv
// CPU-facing I/O responder: switch reads gated by a debounced key press, and
// display writes converted to three BCD seven-segment digits by shift-add-3.
module cpu_io_responder
  import cpu_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_W            = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SW_W-1:0] switch,
  input  logic            btn_enter,
  input  logic            rd_req,
  output logic            rd_valid,
  output logic [31:0]     rd_data,
  output logic            rd_busy,
  input  logic            wr_en,
  input  logic [31:0]     wr_data,
  output logic            wr_ready,
  output logic [6:0]      display2,
  output logic [6:0]      display1,
  output logic [6:0]      display0
);

  logic press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .btn_raw_i (btn_enter),
    .press_o   (press)
  );

  rd_state_t   rd_state_q, rd_state_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Presses outside RD_WAIT are dropped so a stale press never satisfies a later request.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (rd_state_q)
      RD_IDLE: if (rd_req) rd_state_d = RD_WAIT;
      RD_WAIT: begin
        if (press) begin
          rd_valid_d = 1'b1;
          rd_data_d  = 32'(switch);
          rd_state_d = RD_IDLE;
        end else if (!rd_req) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_busy  = (rd_state_q == RD_WAIT);

  wr_state_t   wr_state_q, wr_state_d;
  logic [9:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  iter_q, iter_d;
  logic        ovf_q, ovf_d;
  logic        upd_q, upd_d;
  logic [6:0]  disp2_q, disp2_d, disp1_q, disp1_d, disp0_q, disp0_d;
  logic [11:0] bcd_adj;
  logic [21:0] shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q <= WR_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      ovf_q      <= 1'b0;
      upd_q      <= 1'b0;
      disp2_q    <= SEG_BLANK;
      disp1_q    <= SEG_BLANK;
      disp0_q    <= SEG_BLANK;
    end else begin
      wr_state_q <= wr_state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      ovf_q      <= ovf_d;
      upd_q      <= upd_d;
      disp2_q    <= disp2_d;
      disp1_q    <= disp1_d;
      disp0_q    <= disp0_d;
    end
  end

  // Ten iterations cover the 10-bit binary; the display refresh lands one edge later.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      bcd_adj[n*4 +: 4] = (bcd_q[n*4 +: 4] >= 4'd5) ? bcd_q[n*4 +: 4] + 4'd3
                                                    : bcd_q[n*4 +: 4];
    end
    shifted    = {bcd_adj, bin_q} << 1;
    wr_state_d = wr_state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    ovf_d      = ovf_q;
    upd_d      = 1'b0;
    disp2_d    = disp2_q;
    disp1_d    = disp1_q;
    disp0_d    = disp0_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (wr_en) begin
          ovf_d      = wr_data[31] || (wr_data > DISP_MAX);
          bin_d      = wr_data[9:0];
          bcd_d      = '0;
          iter_d     = '0;
          wr_state_d = WR_CONV;
        end
      end
      WR_CONV: begin
        {bcd_d, bin_d} = shifted;
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'd9) begin
          wr_state_d = WR_IDLE;
          upd_d      = 1'b1;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
    if (upd_q) begin
      disp2_d = ovf_q ? SEG_DASH : seg7(bcd_q[11:8]);
      disp1_d = ovf_q ? SEG_DASH : seg7(bcd_q[7:4]);
      disp0_d = ovf_q ? SEG_DASH : seg7(bcd_q[3:0]);
    end
  end

  assign wr_ready = (wr_state_q == WR_IDLE);
  assign display2 = disp2_q;
  assign display1 = disp1_q;
  assign display0 = disp0_q;

endmodule

// File: tb/tb_cpu_io_responder.sv
// Directed bench for cpu_io_responder with a short debounce window.
module tb_cpu_io_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] switch;
  logic        btn_enter;
  logic        rd_req;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_busy;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [6:0]  display2, display1, display0;

  int checks = 0;
  int passes = 0;
  logic [6:0] prev2 = 7'h7F, prev1 = 7'h7F, prev0 = 7'h7F;

  cpu_io_responder #(.DEBOUNCE_CYCLES(4), .SW_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .switch    (switch),
    .btn_enter (btn_enter),
    .rd_req    (rd_req),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .display2  (display2),
    .display1  (display1),
    .display0  (display0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    int nv;
    logic [31:0] got;
    reset = 1'b1; btn_enter = 1'b0; switch = 16'hFFFF;
    rd_req = 1'b0; wr_en = 1'b0; wr_data = '0;
    idle(3);
    checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL reset_rd_valid got %b want 0", rd_valid); else passes++;
    checks++; if (rd_data !== 32'h0) $display("[TB] FAIL reset_rd_data got %h want 0", rd_data); else passes++;
    checks++; if (rd_busy !== 1'b0) $display("[TB] FAIL reset_rd_busy got %b want 0", rd_busy); else passes++;
    checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL reset_wr_ready got %b want 1", wr_ready); else passes++;
    checks++; if ({display2, display1, display0} !== {7'h7F, 7'h7F, 7'h7F})
      $display("[TB] FAIL reset_displays got %h %h %h want 7f 7f 7f", display2, display1, display0); else passes++;
    reset = 1'b0;
    idle(10);
    rd_req = 1'b1;
    nv = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (rd_valid) nv++; end
    checks++; if (nv !== 0) $display("[TB] FAIL held_press_no_valid got %0d want 0", nv); else passes++;
    checks++; if (rd_busy !== 1'b1) $display("[TB] FAIL held_press_busy got %b want 1", rd_busy); else passes++;
    btn_enter = 1'b1; idle(8);
    btn_enter = 1'b0;
    nv = 0; got = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rd_valid) begin nv++; got = rd_data; rd_req = 1'b0; end
    end
    checks++; if (nv !== 1) $display("[TB] FAIL repress_valid_count got %0d want 1", nv); else passes++;
    checks++; if (got !== 32'h0000FFFF) $display("[TB] FAIL repress_data got %h want 0000ffff", got); else passes++;
    rd_req = 1'b0; btn_enter = 1'b1; idle(8);
  endtask

  task automatic test_read();
    int nv;
    logic [31:0] got;
    logic busyAtValid;
    switch = 16'h00A5; rd_req = 1'b1; tick();
    checks++; if (rd_busy !== 1'b1) $display("[TB] FAIL read_busy_wait got %b want 1", rd_busy); else passes++;
    btn_enter = 1'b0;
    nv = 0; got = '0; busyAtValid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (rd_valid) begin nv++; got = rd_data; busyAtValid = rd_busy; end
    end
    checks++; if (nv !== 1) $display("[TB] FAIL read_valid_count got %0d want 1", nv); else passes++;
    checks++; if (got !== 32'h000000A5) $display("[TB] FAIL read_data got %h want 000000a5", got); else passes++;
    checks++; if (busyAtValid !== 1'b0) $display("[TB] FAIL read_busy_at_valid got %b want 0", busyAtValid); else passes++;
    checks++; if (rd_busy !== 1'b1) $display("[TB] FAIL read_rewait_busy got %b want 1", rd_busy); else passes++;
    rd_req = 1'b0; tick();
    btn_enter = 1'b1; idle(8);
  endtask

  task automatic test_abort();
    int nv;
    switch = 16'h5555;
    rd_req = 1'b1; idle(3);
    rd_req = 1'b0; tick();
    checks++; if (rd_busy !== 1'b0) $display("[TB] FAIL abort_busy got %b want 0", rd_busy); else passes++;
    nv = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (rd_valid) nv++; end
    checks++; if (nv !== 0) $display("[TB] FAIL abort_no_valid got %0d want 0", nv); else passes++;
    checks++; if (rd_data !== 32'h000000A5) $display("[TB] FAIL abort_data_held got %h want 000000a5", rd_data); else passes++;
  endtask

  task automatic test_discard_glitch();
    int nv;
    logic [31:0] got;
    btn_enter = 1'b0; idle(10);
    btn_enter = 1'b1;
    rd_req = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (rd_valid) nv++; end
    checks++; if (rd_busy !== 1'b1) $display("[TB] FAIL discard_busy got %b want 1", rd_busy); else passes++;
    btn_enter = 1'b0; tick(); tick();
    btn_enter = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(); if (rd_valid) nv++; end
    checks++; if (nv !== 0) $display("[TB] FAIL discard_glitch_no_valid got %0d want 0", nv); else passes++;
    switch = 16'h1234; btn_enter = 1'b0;
    nv = 0; got = '0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (rd_valid) begin nv++; got = rd_data; rd_req = 1'b0; end
    end
    checks++; if (nv !== 1) $display("[TB] FAIL fresh_press_count got %0d want 1", nv); else passes++;
    checks++; if (got !== 32'h00001234) $display("[TB] FAIL fresh_press_data got %h want 00001234", got); else passes++;
    rd_req = 1'b0; btn_enter = 1'b1; idle(8);
  endtask

  task automatic do_write(input logic [31:0] val, input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
    int w;
    logic lowOk;
    w = 0;
    while (!wr_ready && w < 30) begin tick(); w++; end
    checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL write_ready_timeout got %b want 1", wr_ready); else passes++;
    wr_en = 1'b1; wr_data = val; tick();
    wr_en = 1'b0;
    lowOk = (wr_ready === 1'b0);
    repeat (9) begin tick(); if (wr_ready !== 1'b0) lowOk = 1'b0; end
    checks++; if (lowOk !== 1'b1) $display("[TB] FAIL write_busy_window val=%0d got ok=%b want 1", val, lowOk); else passes++;
    tick();
    checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL write_ready_t10 val=%0d got %b want 1", val, wr_ready); else passes++;
    checks++; if ({display2, display1, display0} !== {prev2, prev1, prev0})
      $display("[TB] FAIL write_hold_t10 val=%0d got %b %b %b want %b %b %b", val, display2, display1, display0, prev2, prev1, prev0); else passes++;
    tick();
    checks++; if ({display2, display1, display0} !== {e2, e1, e0})
      $display("[TB] FAIL write_digits val=%0d got %b %b %b want %b %b %b", val, display2, display1, display0, e2, e1, e0); else passes++;
    prev2 = e2; prev1 = e1; prev0 = e0;
  endtask

  task automatic test_write();
    do_write(32'd9,          7'b1000000, 7'b1000000, 7'b0010000);
    do_write(32'd742,        7'b1111000, 7'b0011001, 7'b0100100);
    do_write(32'd1000,       7'b0111111, 7'b0111111, 7'b0111111);
    do_write(32'd5,          7'b1000000, 7'b1000000, 7'b0010010);
    do_write(32'hFFFFFFFF,   7'b0111111, 7'b0111111, 7'b0111111);
    do_write(32'd999,        7'b0010000, 7'b0010000, 7'b0010000);
  endtask

  task automatic test_concurrent();
    int nv;
    logic [31:0] got;
    switch = 16'h0BEE; rd_req = 1'b1; btn_enter = 1'b0;
    wr_en = 1'b1; wr_data = 32'd123; tick();
    nv = 0; got = '0;
    for (int k = 1; k <= 11; k++) begin
      wr_en = (k == 3);
      wr_data = (k == 3) ? 32'd456 : 32'd123;
      tick();
      if (rd_valid) begin nv++; got = rd_data; rd_req = 1'b0; end
    end
    wr_en = 1'b0;
    checks++; if ({display2, display1, display0} !== {7'b1111001, 7'b0100100, 7'b0110000})
      $display("[TB] FAIL concurrent_digits got %b %b %b want 1111001 0100100 0110000", display2, display1, display0); else passes++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_valid) begin nv++; got = rd_data; rd_req = 1'b0; end
    end
    checks++; if (nv !== 1) $display("[TB] FAIL concurrent_read_count got %0d want 1", nv); else passes++;
    checks++; if (got !== 32'h00000BEE) $display("[TB] FAIL concurrent_read_data got %h want 00000bee", got); else passes++;
    rd_req = 1'b0; btn_enter = 1'b1; idle(8);
  endtask

  task automatic test_mid_reset();
    rd_req = 1'b1; idle(2);
    checks++; if (rd_busy !== 1'b1) $display("[TB] FAIL midreset_busy_before got %b want 1", rd_busy); else passes++;
    wr_en = 1'b1; wr_data = 32'd888; tick();
    wr_en = 1'b0;
    idle(5);
    reset = 1'b1; #1;
    checks++; if ({display2, display1, display0} !== {7'h7F, 7'h7F, 7'h7F})
      $display("[TB] FAIL midreset_displays got %h %h %h want 7f 7f 7f", display2, display1, display0); else passes++;
    checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL midreset_wr_ready got %b want 1", wr_ready); else passes++;
    checks++; if (rd_busy !== 1'b0) $display("[TB] FAIL midreset_rd_busy got %b want 0", rd_busy); else passes++;
    checks++; if (rd_data !== 32'h0) $display("[TB] FAIL midreset_rd_data got %h want 0", rd_data); else passes++;
    rd_req = 1'b0;
    tick();
    reset = 1'b0;
    idle(15);
    checks++; if ({display2, display1, display0} !== {7'h7F, 7'h7F, 7'h7F})
      $display("[TB] FAIL midreset_no_late_update got %h %h %h want 7f 7f 7f", display2, display1, display0); else passes++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_abort();
    test_discard_glitch();
    test_write();
    test_concurrent();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
